// File: rtl/adder_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adder_arbiter : round-robin arbiter sharing one registered adder among four
//                 requesters. Revision 1.0
// ----------------------------------------------------------------------------
module adder_arbiter #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req_valid,
  input  logic [4*W-1:0] req_a,
  input  logic [4*W-1:0] req_b,
  output logic [3:0]     req_ready,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  output logic           add_en,
  input  logic [W:0]     add_sum,
  output logic           rsp_valid,
  output logic [1:0]     rsp_id,
  output logic [W:0]     rsp_sum,
  input  logic           rsp_ready,
  output logic           busy,
  output logic [7:0]     done_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0] state;
  logic [1:0] last;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic       accept;

  // First requesting index after the last accepted one, wrapping modulo 4.
  always_comb begin
    winner = last;
    found  = 1'b0;
    cand   = last;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign accept    = (state == IDLE) && (req_valid != 4'd0);
  assign req_ready = accept ? (4'b0001 << winner) : 4'b0000;
  assign add_en    = (state == ISSUE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last     <= 2'd3;
      add_a    <= '0;
      add_b    <= '0;
      rsp_id   <= 2'd0;
      rsp_sum  <= '0;
      done_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            add_a  <= req_a[winner*W +: W];
            add_b  <= req_b[winner*W +: W];
            rsp_id <= winner;
            last   <= winner;
            state  <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          rsp_sum <= add_sum;
          state   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            done_cnt <= done_cnt + 8'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: W, default 4, operand width. Sum width is W+1.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  4  per-requester request; bit i belongs to requester i.
REQ-005 req_a  input  4*W  operands A; requester i uses bits [i*W +: W].
REQ-006 req_b  input  4*W  operands B; same packing as req_a.
REQ-007 req_ready  output  4  one-hot grant/accept pulse, or all zero.
REQ-008 add_a  output  W  operand A driven to the shared registered adder.
REQ-009 add_b  output  W  operand B driven to the shared registered adder.
REQ-010 add_en  output  1  adder enable; the adder registers add_a+add_b on the next clk edge.
REQ-011 add_sum  input  W+1  registered sum returned by the shared adder.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_id  output  2  index of the requester that owns the result.
REQ-014 rsp_sum  output  W+1  captured result.
REQ-015 rsp_ready  input  1  consumer accepts the result.
REQ-016 busy  output  1  high whenever state != IDLE.
REQ-017 done_cnt  output  8  count of completed responses.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP. The FSM shall advance one state per clk edge, except IDLE and RESP, which hold as given in REQ-019 and REQ-022.
REQ-019 IDLE:
- if req_valid == 0, the FSM shall stay in IDLE;
- otherwise it shall select winner w by round-robin, searching from (last+1) mod 4 upward with wrap, where last is the index of the previously accepted requester;
- it shall assert req_ready[w] combinationally in that same cycle;
- on the clk edge it shall latch req_a[w], req_b[w] and w, set last = w, and move to ISSUE.
REQ-020 req_ready shall be all zero in every state other than IDLE; requests present during ISSUE, WAIT or RESP are not accepted and wait for IDLE.
REQ-021 ISSUE: add_en=1 for exactly one cycle, with add_a/add_b equal to the latched operands; next state WAIT.
REQ-022 WAIT and RESP:
- WAIT: add_en=0; on the clk edge capture add_sum into rsp_sum; next state RESP.
- RESP: rsp_valid=1, and rsp_sum/rsp_id shall stay stable until rsp_ready=1 is sampled high. On that edge: done_cnt+1, then IDLE.
REQ-023 Latency: accept edge at cycle T gives rsp_valid high from cycle T+3. The earliest next accept is the cycle after the response handshake. Peak throughput is 1 operation per 4 cycles.
REQ-024 add_en shall be 0 outside ISSUE; add_a/add_b shall hold the last latched operands outside ISSUE.
REQ-025 Arithmetic: rsp_sum equals the zero-extended add_sum, full W+1 bits, no truncation; 15+15 = 30 for W=4.
REQ-026 A requester that deasserts req_valid before it is granted is skipped with no side effect. Operands are sampled only on the accept edge; changing them after acceptance does not affect the result.
REQ-027 done_cnt shall wrap 255 -> 0 with no flag.
REQ-028 A rsp_ready pulse outside RESP shall be ignored.

Reset
REQ-029 rst=0 shall asynchronously force:
- state=IDLE, last=3 (requester 0 has first priority);
- req_ready=0, add_en=0, add_a=0, add_b=0;
- rsp_valid=0, rsp_id=0, rsp_sum=0, busy=0, done_cnt=0.
REQ-030 Reset asserted in any state, including mid-ISSUE/WAIT/RESP, shall abort the operation and produce no response. Operation resumes from IDLE on the first clk edge after rst rises.

Verification
REQ-031 Single request: after reset, req_valid=0001 with A0=3, B0=3 and rsp_ready=1 -> req_ready=0001 for one cycle; add_en pulses 1 cycle later; rsp_valid 3 cycles after accept with rsp_id=0, rsp_sum=6; done_cnt=1.
REQ-032 Round-robin: req_valid=1111 held continuously, A_i=i, B_i=1 -> grants in order 0,1,2,3,0. Each rsp_sum=i+1 with the matching rsp_id.
REQ-033 Backpressure: rsp_ready=0 for 10 cycles while in RESP -> rsp_valid, rsp_sum and rsp_id stay stable, req_ready stays 0 even with requests pending. rsp_ready=1 -> one completion, then IDLE.
REQ-034 Boundary: A=15, B=15 -> rsp_sum=30. 256 completions -> done_cnt wraps to 0.
REQ-035 Reset mid-operation: rst=0 during WAIT -> rsp_valid never asserts for that request, all outputs at reset values. After release, req_valid=0100 is granted on the first IDLE cycle.
REQ-036 Random: 500 cycles of random req_valid, operands and rsp_ready, checked against a scoreboard -> every accepted request yields exactly one response with the correct sum and id, and no requester is starved beyond 3 other grants.
